pjon_line_cond: RTL

//   Pad-side conditioner between the PJON pad and the PJDL wrapper in the user domain.

---
 rtl/pjon_line_cond_if.sv | 38 +++
 rtl/pjon_line_cond.sv | 108 ++++++++++
 2 files changed

// File: rtl/pjon_line_cond_if.sv
// Pad-side and PJDL-side signal bundle for pjon_line_cond.
// loopback_i exists only when PJON_LINE_COND_LOOPBACK_EN is defined.
interface pjon_line_cond_if #(
    parameter int unsigned IdleCntWidth = 16
);
    logic                    pad_i;
    logic                    pad_o;
    logic                    pad_en_o;
    logic                    pjdl_o;
    logic                    pjdl_i;
    logic                    pjdl_en_i;
    logic [IdleCntWidth-1:0] idle_thresh_i;
    logic                    bus_idle_o;
    logic                    collision_o;
`ifdef PJON_LINE_COND_LOOPBACK_EN
    logic                    loopback_i;

    modport slave (
        input  pad_i, pjdl_i, pjdl_en_i, idle_thresh_i,
        output pad_o, pad_en_o, pjdl_o, bus_idle_o, collision_o,
        input  loopback_i
    );
    modport master (
        output pad_i, pjdl_i, pjdl_en_i, idle_thresh_i,
        input  pad_o, pad_en_o, pjdl_o, bus_idle_o, collision_o,
        output loopback_i
    );
`else
    modport slave (
        input  pad_i, pjdl_i, pjdl_en_i, idle_thresh_i,
        output pad_o, pad_en_o, pjdl_o, bus_idle_o, collision_o
    );
    modport master (
        output pad_i, pjdl_i, pjdl_en_i, idle_thresh_i,
        input  pad_o, pad_en_o, pjdl_o, bus_idle_o, collision_o
    );
`endif
endinterface

// File: rtl/pjon_line_cond.sv
// PJON pad conditioner: line synchroniser/deglitcher, registered drive, bus-idle and collision detect.
// Optional open-drain loopback is enabled by defining PJON_LINE_COND_LOOPBACK_EN.
module pjon_line_cond #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterLen    = 4,
    parameter int unsigned IdleCntWidth = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    pjon_line_cond_if.slave bus
);
    localparam int unsigned FiltCntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;
    localparam int unsigned DrvLen   = SyncStages + FilterLen + 1;
    localparam int unsigned DrvCntW  = $clog2(DrvLen + 1);

    logic [SyncStages-1:0]   sync_q, sync_d;
    logic                    filt_q, filt_d;
    logic [FiltCntW-1:0]     fcnt_q, fcnt_d;
    logic                    pad_o_q, pad_o_d;
    logic                    pad_en_q, pad_en_d;
    logic                    pad_prev_q;
    logic [IdleCntWidth-1:0] idle_cnt_q, idle_cnt_d;
    logic                    bus_idle_q, bus_idle_d;
    logic [DrvCntW-1:0]      drv_cnt_q, drv_cnt_d;
    logic                    armed_q, armed_d;
    logic                    coll_q, coll_d;
    logic                    line_in;
    logic                    s;
    logic                    drv_clr;

`ifdef PJON_LINE_COND_LOOPBACK_EN
    // Open-drain model: released line floats high; internal enable still governs collision.
    assign line_in      = bus.loopback_i ? ((pad_o_q & pad_en_q) | ~pad_en_q) : bus.pad_i;
    assign bus.pad_en_o = pad_en_q & ~bus.loopback_i;
`else
    assign line_in      = bus.pad_i;
    assign bus.pad_en_o = pad_en_q;
`endif

    assign s               = sync_q[SyncStages-1];
    assign bus.pad_o       = pad_o_q;
    assign bus.pjdl_o      = filt_q;
    assign bus.bus_idle_o  = bus_idle_q;
    assign bus.collision_o = coll_q;

    always_comb begin
        sync_d   = {sync_q[SyncStages-2:0], line_in};
        pad_o_d  = bus.pjdl_i;
        pad_en_d = bus.pjdl_en_i;

        filt_d = filt_q;
        fcnt_d = '0;
        if (s != filt_q) begin
            if (fcnt_q == FiltCntW'(FilterLen - 1)) begin
                filt_d = s;
            end else begin
                fcnt_d = fcnt_q + FiltCntW'(1);
            end
        end

        idle_cnt_d = idle_cnt_q;
        if (filt_q || bus.pjdl_en_i) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + IdleCntWidth'(1);
        end
        bus_idle_d = (idle_cnt_q >= bus.idle_thresh_i) && !filt_q && !bus.pjdl_en_i;

        // A drive change seen on the same cycle as a mismatch suppresses the pulse.
        drv_clr   = !pad_en_q || (pad_o_q != pad_prev_q);
        coll_d    = armed_q && !drv_clr && (drv_cnt_q == DrvCntW'(DrvLen)) && (filt_q != pad_o_q);
        drv_cnt_d = drv_cnt_q;
        if (drv_clr) begin
            drv_cnt_d = '0;
        end else if (drv_cnt_q != DrvCntW'(DrvLen)) begin
            drv_cnt_d = drv_cnt_q + DrvCntW'(1);
        end
        armed_d = drv_clr ? 1'b1 : (coll_d ? 1'b0 : armed_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            fcnt_q     <= '0;
            pad_o_q    <= 1'b0;
            pad_en_q   <= 1'b0;
            pad_prev_q <= 1'b0;
            idle_cnt_q <= '0;
            bus_idle_q <= 1'b0;
            drv_cnt_q  <= '0;
            armed_q    <= 1'b1;
            coll_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            pad_o_q    <= pad_o_d;
            pad_en_q   <= pad_en_d;
            pad_prev_q <= pad_o_q;
            idle_cnt_q <= idle_cnt_d;
            bus_idle_q <= bus_idle_d;
            drv_cnt_q  <= drv_cnt_d;
            armed_q    <= armed_d;
            coll_q     <= coll_d;
        end
    end
endmodule
